// File: rtl/vector_dram_master.sv
// Initiator for the vector data RAM port: one load/store at a time, byte-mask
// generation for element stores, registered load return with valid/ready.
module vector_dram_master (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [0:2]     req_op,
    input  logic [0:31]    req_ea,
    input  logic [0:127]   req_data,
    input  logic [0:4]     req_tag,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [0:127]   resp_data,
    output logic [0:4]     resp_tag,
    output logic           dram_cs,
    output logic           dram_rw,
    output logic [0:31]    dram_addr,
    output logic [0:127]   dram_data_in,
    output logic [0:15]    dram_write_en,
    input  logic [0:127]   dram_data_out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ST   = 3'd1,
        S_LD   = 3'd2,
        S_CAP  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [0:4]     tag_r;
    logic [0:4]     tag_s;
    logic           req_ready_s;
    logic           resp_valid_s;
    logic [0:127]   resp_data_s;
    logic [0:4]     resp_tag_s;
    logic           dram_cs_s;
    logic           dram_rw_s;
    logic [0:31]    dram_addr_s;
    logic [0:127]   dram_data_in_s;
    logic [0:15]    dram_write_en_s;

    // Byte-lane enables; lane 0 is the MSB of the mask. Low EA bits below the
    // element size are dropped by the alignment of the start lane.
    function automatic logic [0:15] lane_mask(input logic [0:1] size, input logic [0:3] lo);
        logic [0:15] m;
        case (size)
            2'b00:   m = 16'hFFFF;
            2'b01:   m = 16'h8000 >> lo;
            2'b10:   m = 16'hC000 >> {lo[0:2], 1'b0};
            2'b11:   m = 16'hF000 >> {lo[0:1], 2'b00};
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    // Next-state and next-output computation; all outputs are registered below.
    always_comb begin
        state_s         = state_r;
        tag_s           = tag_r;
        req_ready_s     = 1'b0;
        resp_valid_s    = 1'b0;
        resp_data_s     = resp_data;
        resp_tag_s      = resp_tag;
        dram_cs_s       = 1'b0;
        dram_rw_s       = 1'b1;
        dram_addr_s     = dram_addr;
        dram_data_in_s  = dram_data_in;
        dram_write_en_s = 16'h0000;
        case (state_r)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    tag_s       = req_tag;
                    dram_cs_s   = 1'b1;
                    dram_addr_s = {req_ea[0:27], 4'b0000};
                    if (req_op[0]) begin
                        state_s         = S_ST;
                        dram_rw_s       = 1'b0;
                        dram_data_in_s  = req_data;
                        dram_write_en_s = lane_mask(req_op[1:2], req_ea[28:31]);
                    end else begin
                        state_s = S_LD;
                    end
                end else begin
                    req_ready_s = 1'b1;
                end
            end
            S_ST: begin
                state_s     = S_IDLE;
                req_ready_s = 1'b1;
            end
            S_LD: begin
                state_s = S_CAP;
            end
            S_CAP: begin
                // RAM read data is valid this cycle, one cycle after the strobe.
                state_s      = S_RESP;
                resp_valid_s = 1'b1;
                resp_data_s  = dram_data_out;
                resp_tag_s   = tag_r;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_s     = S_IDLE;
                    req_ready_s = 1'b1;
                end else begin
                    resp_valid_s = 1'b1;
                end
            end
            default: begin
                state_s     = S_IDLE;
                req_ready_s = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            tag_r         <= 5'd0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_data     <= 128'd0;
            resp_tag      <= 5'd0;
            dram_cs       <= 1'b0;
            dram_rw       <= 1'b1;
            dram_addr     <= 32'd0;
            dram_data_in  <= 128'd0;
            dram_write_en <= 16'h0000;
        end else begin
            state_r       <= state_s;
            tag_r         <= tag_s;
            req_ready     <= req_ready_s;
            resp_valid    <= resp_valid_s;
            resp_data     <= resp_data_s;
            resp_tag      <= resp_tag_s;
            dram_cs       <= dram_cs_s;
            dram_rw       <= dram_rw_s;
            dram_addr     <= dram_addr_s;
            dram_data_in  <= dram_data_in_s;
            dram_write_en <= dram_write_en_s;
        end
    end

endmodule

// File: tb/tb_vector_dram_master.sv
// Directed self-checking bench for vector_dram_master with a registered-read
// byte-writable RAM model on the dram_* pins.
module tb_vector_dram_master;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [0:2]     req_op;
    logic [0:31]    req_ea;
    logic [0:127]   req_data;
    logic [0:4]     req_tag;
    logic           resp_valid;
    logic           resp_ready;
    logic [0:127]   resp_data;
    logic [0:4]     resp_tag;
    logic           dram_cs;
    logic           dram_rw;
    logic [0:31]    dram_addr;
    logic [0:127]   dram_data_in;
    logic [0:15]    dram_write_en;
    logic [0:127]   dram_data_out;

    logic [0:127]   mem [0:255];

    int total = 0;
    int bad   = 0;

    localparam logic [0:127] D1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [0:127] DB  = 128'hEEEEEEEE_EEA5EEEE_EEEEEEEE_EEEEEEEE;
    localparam logic [0:127] E2  = 128'h00112233_44A56677_8899AABB_CCDDEEFF;
    localparam logic [0:127] DH  = 128'h77777777_77777777_7777DEAD_77777777;
    localparam logic [0:127] DW  = 128'h55555555_55555555_55555555_CAFEF00D;
    localparam logic [0:127] E3H = 128'h00112233_44A56677_8899DEAD_CCDDEEFF;
    localparam logic [0:127] E3  = 128'h00112233_44A56677_8899DEAD_CAFEF00D;
    localparam logic [0:127] DP  = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    localparam logic [0:127] D6  = 128'hFEDCBA98_76543210_13579BDF_2468ACE0;

    always #5 clk = ~clk;

    vector_dram_master dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_ea        (req_ea),
        .req_data      (req_data),
        .req_tag       (req_tag),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag),
        .dram_cs       (dram_cs),
        .dram_rw       (dram_rw),
        .dram_addr     (dram_addr),
        .dram_data_in  (dram_data_in),
        .dram_write_en (dram_write_en),
        .dram_data_out (dram_data_out)
    );

    // RAM model: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (dram_cs && !dram_rw) begin
            for (int i = 0; i < 16; i++) begin
                if (dram_write_en[i]) mem[dram_addr[20:27]][8*i +: 8] <= dram_data_in[8*i +: 8];
            end
        end
        if (dram_cs && dram_rw) dram_data_out <= mem[dram_addr[20:27]];
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [0:2] op, input logic [0:31] ea,
                            input logic [0:127] data, input logic [0:15] exp_we);
        req_valid = 1'b1; req_op = op; req_ea = ea; req_data = data;
        tick();
        check_eq("st_cs",   128'(dram_cs), 128'(1'b1));
        check_eq("st_rw",   128'(dram_rw), 128'(1'b0));
        check_eq("st_addr", 128'(dram_addr), 128'({ea[0:27], 4'b0000}));
        check_eq("st_we",   128'(dram_write_en), 128'(exp_we));
        check_eq("st_data", 128'(dram_data_in), 128'(data));
        check_eq("st_rdy0", 128'(req_ready), 128'(1'b0));
        req_valid = 1'b0;
        tick();
        check_eq("st_cs_off", 128'(dram_cs), 128'(1'b0));
        check_eq("st_we_off", 128'(dram_write_en), 128'(16'h0000));
        check_eq("st_rdy1",   128'(req_ready), 128'(1'b1));
    endtask

    task automatic do_load(input logic [0:2] op, input logic [0:31] ea,
                           input logic [0:4] tag, input logic [0:127] exp_data);
        req_valid = 1'b1; req_op = op; req_ea = ea; req_tag = tag; resp_ready = 1'b1;
        tick();
        check_eq("ld_cs",   128'(dram_cs), 128'(1'b1));
        check_eq("ld_rw",   128'(dram_rw), 128'(1'b1));
        check_eq("ld_we",   128'(dram_write_en), 128'(16'h0000));
        check_eq("ld_addr", 128'(dram_addr), 128'({ea[0:27], 4'b0000}));
        req_valid = 1'b0;
        tick();
        check_eq("ld_cs_off", 128'(dram_cs), 128'(1'b0));
        check_eq("ld_rv_e1",  128'(resp_valid), 128'(1'b0));
        tick();
        check_eq("ld_rv_e2", 128'(resp_valid), 128'(1'b1));
        check_eq("ld_data",  128'(resp_data), 128'(exp_data));
        check_eq("ld_tag",   128'(resp_tag), 128'(tag));
        tick();
        check_eq("ld_rv_e3", 128'(resp_valid), 128'(1'b0));
        check_eq("ld_rdy",   128'(req_ready), 128'(1'b1));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 128'd0;
        rst = 1'b1; req_valid = 1'b0; req_op = 3'b000; req_ea = 32'd0;
        req_data = 128'd0; req_tag = 5'd0; resp_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_ready",  128'(req_ready), 128'(1'b1));
        check_eq("rst_rvalid", 128'(resp_valid), 128'(1'b0));
        check_eq("rst_rdata",  128'(resp_data), 128'd0);
        check_eq("rst_rtag",   128'(resp_tag), 128'd0);
        check_eq("rst_cs",     128'(dram_cs), 128'(1'b0));
        check_eq("rst_rw",     128'(dram_rw), 128'(1'b1));
        check_eq("rst_addr",   128'(dram_addr), 128'd0);
        check_eq("rst_din",    128'(dram_data_in), 128'd0);
        check_eq("rst_we",     128'(dram_write_en), 128'd0);
        rst = 1'b0;
        tick();

        // Full-vector store and read back.
        do_store(3'b100, 32'h0000_0040, D1, 16'hFFFF);
        do_load(3'b000, 32'h0000_0040, 5'd3, D1);

        // Element stores: byte, halfword, word with ignored low EA bits.
        do_store(3'b101, 32'h0000_0045, DB, 16'h0400);
        do_load(3'b000, 32'h0000_0040, 5'd4, E2);
        do_store(3'b110, 32'h0000_004B, DH, 16'h0030);
        do_load(3'b000, 32'h0000_0040, 5'd6, E3H);
        do_store(3'b111, 32'h0000_004E, DW, 16'h000F);
        do_load(3'b011, 32'h0000_0040, 5'd8, E3);

        // Back-pressure on the response with a pending request.
        req_valid = 1'b1; req_op = 3'b000; req_ea = 32'h0000_0040; req_tag = 5'd7;
        tick();
        req_op = 3'b100; req_ea = 32'h0000_0080; req_data = DP; req_tag = 5'd1;
        resp_ready = 1'b0;
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            check_eq("bp_rv",   128'(resp_valid), 128'(1'b1));
            check_eq("bp_data", 128'(resp_data), 128'(E3));
            check_eq("bp_tag",  128'(resp_tag), 128'(5'd7));
            check_eq("bp_rdy",  128'(req_ready), 128'(1'b0));
            check_eq("bp_cs",   128'(dram_cs), 128'(1'b0));
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check_eq("bp_hs_rv",  128'(resp_valid), 128'(1'b0));
        check_eq("bp_hs_rdy", 128'(req_ready), 128'(1'b1));
        check_eq("bp_hs_cs",  128'(dram_cs), 128'(1'b0));
        tick();
        check_eq("bp_acc_cs",   128'(dram_cs), 128'(1'b1));
        check_eq("bp_acc_rw",   128'(dram_rw), 128'(1'b0));
        check_eq("bp_acc_addr", 128'(dram_addr), 128'(32'h0000_0080));
        req_valid = 1'b0;
        tick();
        check_eq("bp_done_rdy", 128'(req_ready), 128'(1'b1));

        // Reset during the read strobe drops the load.
        req_valid = 1'b1; req_op = 3'b000; req_ea = 32'h0000_0040; req_tag = 5'd9;
        tick();
        check_eq("rl_cs_on", 128'(dram_cs), 128'(1'b1));
        rst = 1'b1; req_valid = 1'b0;
        tick();
        rst = 1'b0;
        check_eq("rl_cs",   128'(dram_cs), 128'(1'b0));
        check_eq("rl_rdy",  128'(req_ready), 128'(1'b1));
        check_eq("rl_addr", 128'(dram_addr), 128'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("rl_rv", 128'(resp_valid), 128'(1'b0));
        end
        do_load(3'b001, 32'h0000_0040, 5'd2, E3);

        // Back-to-back store then load with req_valid held high.
        req_valid = 1'b1; req_op = 3'b100; req_ea = 32'h0000_0080; req_data = D6;
        resp_ready = 1'b1;
        tick();
        check_eq("b2b_st_cs", 128'(dram_cs), 128'(1'b1));
        check_eq("b2b_st_rw", 128'(dram_rw), 128'(1'b0));
        req_op = 3'b000; req_tag = 5'd5;
        tick();
        check_eq("b2b_e1_rdy", 128'(req_ready), 128'(1'b1));
        check_eq("b2b_e1_cs",  128'(dram_cs), 128'(1'b0));
        tick();
        check_eq("b2b_ld_cs", 128'(dram_cs), 128'(1'b1));
        check_eq("b2b_ld_rw", 128'(dram_rw), 128'(1'b1));
        check_eq("b2b_rdy0",  128'(req_ready), 128'(1'b0));
        req_valid = 1'b0;
        tick();
        check_eq("b2b_e3_rv", 128'(resp_valid), 128'(1'b0));
        tick();
        check_eq("b2b_rv",   128'(resp_valid), 128'(1'b1));
        check_eq("b2b_data", 128'(resp_data), 128'(D6));
        check_eq("b2b_tag",  128'(resp_tag), 128'(5'd5));
        tick();
        check_eq("b2b_end_rv", 128'(resp_valid), 128'(1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
